sram_controller: RTL and testbench

- Memory-side responder to the data cache's SRAM request interface.
- Accepts single-word (32-bit) writes and line (64-bit) reads, and sequences them onto an external asynchronous 256K x 16 SRAM.
- Returns one-cycle `ready` completion to the cache/MEM stage.
- Sits between the cache and the board SRAM pins.

---
 rtl/sram_controller.sv | 110 +++++++++++
 tb/tb_sram_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - cache-side responder sequencing word writes and line reads onto a 256K x 16 async SRAM
module sram_controller #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic [63:0] read_data,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_next;
    logic [1:0]  hw_cnt;
    logic [3:0]  cyc_cnt;
    logic        last_cyc;
    logic        dq_drive;
    logic [15:0] dq_out;
    logic        unused_bits;

    assign unused_bits = ^{address[31:19], address[0]};
    assign last_cyc    = (cyc_cnt == LAST_CYC);

    assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hw_cnt    <= 2'd0;
            cyc_cnt   <= 4'd0;
            read_data <= 64'd0;
        end else begin
            state <= state_next;
            if (state == READ || state == WRITE) begin
                if (last_cyc) begin
                    cyc_cnt <= 4'd0;
                    hw_cnt  <= hw_cnt + 2'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + 4'd1;
                end
            end else begin
                cyc_cnt <= 4'd0;
                hw_cnt  <= 2'd0;
            end
            // Sample the bus at the end of each access, after the SRAM output has settled.
            if (state == READ && last_cyc) begin
                read_data[16*hw_cnt +: 16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        SRAM_ADDR  = 18'd0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        dq_drive   = 1'b0;
        dq_out     = 16'd0;
        case (state)
            IDLE: begin
                ready = !read_en && !write_en;
                if (write_en) begin
                    state_next = WRITE;
                end else if (read_en) begin
                    state_next = READ;
                end
            end
            READ: begin
                SRAM_ADDR = {address[18:3], hw_cnt};
                SRAM_OE_N = 1'b0;
                if (last_cyc && hw_cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                SRAM_ADDR = {address[18:2], hw_cnt[0]};
                dq_drive  = 1'b1;
                dq_out    = hw_cnt[0] ? write_data[31:16] : write_data[15:0];
                // WE_N rises one cycle early so address and data hold past the latching edge.
                SRAM_WE_N = last_cyc;
                if (last_cyc && hw_cnt[0]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with behavioural async SRAM models
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        re0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
    logic        rdy0;
    logic [63:0] rd0;
    wire  [15:0] dq0;
    logic [17:0] sa0;
    logic        we_n0, oe_n0, ce0, ub0, lb0;

    logic        re1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = 32'd0, wd1 = 32'd0;
    logic        rdy1;
    logic [63:0] rd1;
    wire  [15:0] dq1;
    logic [17:0] sa1;
    logic        we_n1, oe_n1, ce1, ub1, lb1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    sram_controller #(.ACCESS_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .read_en(re0), .write_en(we0), .address(addr0),
        .write_data(wd0), .ready(rdy0), .read_data(rd0), .SRAM_DQ(dq0),
        .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0),
        .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.ACCESS_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .read_en(re1), .write_en(we1), .address(addr1),
        .write_data(wd1), .ready(rdy1), .read_data(rd1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1),
        .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Undriven bus floats to all ones so a released DQ is observable.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq0[i]);
        pullup (dq1[i]);
    end

    assign dq0 = (!oe_n0 && we_n0) ? mem0[sa0] : 16'bz;
    assign dq1 = (!oe_n1 && we_n1) ? mem1[sa1] : 16'bz;
    always @(posedge we_n0) mem0[sa0] <= dq0;
    always @(posedge we_n1) mem1[sa1] <= dq1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy0 && n < 40);
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic [17:0] sa;
        logic        we_n;
        logic        oe_n;
        logic [15:0] dq;
        logic [63:0] rd;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int n, m, wecnt, oecnt;

        tbl[0]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, 18'h204, 1'b0, 1'b1, 16'hBEEF, 64'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, 18'h204, 1'b1, 1'b1, 16'hBEEF, 64'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, 18'h205, 1'b0, 1'b1, 16'hDEAD, 64'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0, 18'h205, 1'b1, 1'b1, 16'hDEAD, 64'h0};
        tbl[5]  = '{1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b1, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h408, 32'h0,        1'b1, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h204, 1'b1, 1'b0, 16'hBEEF, 64'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h204, 1'b1, 1'b0, 16'hBEEF, 64'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h205, 1'b1, 1'b0, 16'hDEAD, 64'h0000_0000_0000_BEEF};
        tbl[11] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h205, 1'b1, 1'b0, 16'hDEAD, 64'h0000_0000_0000_BEEF};
        tbl[12] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h206, 1'b1, 1'b0, 16'h3344, 64'h0000_0000_DEAD_BEEF};
        tbl[13] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h206, 1'b1, 1'b0, 16'h3344, 64'h0000_0000_DEAD_BEEF};
        tbl[14] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h207, 1'b1, 1'b0, 16'h1122, 64'h0000_3344_DEAD_BEEF};
        tbl[15] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b0, 18'h207, 1'b1, 1'b0, 16'h1122, 64'h0000_3344_DEAD_BEEF};
        tbl[16] = '{1'b1, 1'b0, 32'h40C, 32'h0,        1'b1, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h1122_3344_DEAD_BEEF};
        tbl[17] = '{1'b0, 1'b0, 32'h40C, 32'h0,        1'b1, 18'h0,   1'b1, 1'b1, 16'hFFFF, 64'h1122_3344_DEAD_BEEF};

        mem0[18'h206] = 16'h3344;
        mem0[18'h207] = 16'h1122;
        mem1[18'h3FFFC] = 16'hA001;
        mem1[18'h3FFFD] = 16'hA002;
        mem1[18'h3FFFE] = 16'hA003;
        mem1[18'h3FFFF] = 16'hA004;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("reset_ready", 64'(rdy0), 64'h1);
        check("reset_read_data", rd0, 64'h0);
        check("reset_we_n", 64'(we_n0), 64'h1);
        check("reset_oe_n", 64'(oe_n0), 64'h1);
        check("reset_dq_released", 64'(dq0), 64'hFFFF);
        check("reset_sram_addr", 64'(sa0), 64'h0);
        check("tied_ce_ub_lb", 64'({ce0, ub0, lb0}), 64'h0);
        check("reset_ready_ac4", 64'(rdy1), 64'h1);

        // Write 0xDEADBEEF at 0x408 then read the line at 0x40C
        for (int i = 0; i < 18; i++) begin
            re0   = tbl[i].re;
            we0   = tbl[i].we;
            addr0 = tbl[i].addr;
            wd0   = tbl[i].wd;
            #1;
            check($sformatf("vec%0d_ready", i), 64'(rdy0), 64'(tbl[i].rdy));
            check($sformatf("vec%0d_sram_addr", i), 64'(sa0), 64'(tbl[i].sa));
            check($sformatf("vec%0d_we_n", i), 64'(we_n0), 64'(tbl[i].we_n));
            check($sformatf("vec%0d_oe_n", i), 64'(oe_n0), 64'(tbl[i].oe_n));
            check($sformatf("vec%0d_dq", i), 64'(dq0), 64'(tbl[i].dq));
            check($sformatf("vec%0d_read_data", i), rd0, tbl[i].rd);
            tick();
        end

        // Simultaneous read and write: write wins, exactly two write accesses
        re0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wd0 = 32'hCAFEF00D;
        n = 0; wecnt = 0; oecnt = 0;
        do begin
            tick();
            n++;
            if (!we_n0) wecnt++;
            if (!oe_n0) oecnt++;
        end while (!rdy0 && n < 40);
        re0 = 1'b0; we0 = 1'b0;
        check("both_latency", 64'(n), 64'd5);
        check("both_write_strobes", 64'(wecnt), 64'd2);
        check("both_no_read_cycles", 64'(oecnt), 64'd0);
        check("both_mem_lo", 64'(mem0[18'h80]), 64'hF00D);
        check("both_mem_hi", 64'(mem0[18'h81]), 64'hCAFE);
        tick();

        // Reset during the third halfword of a read
        re0 = 1'b1; addr0 = 32'h40C;
        repeat (5) tick();
        check("midrst_pre_addr", 64'(sa0), 64'h206);
        rst = 1'b0;
        #1;
        check("midrst_oe_n", 64'(oe_n0), 64'h1);
        check("midrst_we_n", 64'(we_n0), 64'h1);
        check("midrst_dq_released", 64'(dq0), 64'hFFFF);
        check("midrst_sram_addr", 64'(sa0), 64'h0);
        re0 = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        check("midrst_no_completion_idle_ready", 64'(rdy0), 64'h1);
        check("midrst_read_data_cleared", rd0, 64'h0);
        re0 = 1'b1;
        wait_ready0(n);
        check("postrst_read_latency", 64'(n), 64'd9);
        check("postrst_read_data", rd0, 64'h1122_3344_DEAD_BEEF);

        // Back-to-back reads with read_en held across DONE
        m = 0;
        do begin
            tick();
            m++;
            if (m == 1) check("b2b_idle_not_ready", 64'(rdy0), 64'h0);
            if (m == 2) check("b2b_restart_hw0", 64'(sa0), 64'h204);
        end while (!rdy0 && m < 40);
        check("b2b_ready_spacing", 64'(m), 64'd10);
        check("b2b_read_data", rd0, 64'h1122_3344_DEAD_BEEF);
        re0 = 1'b0;
        tick();

        // ACCESS_CYCLES = 4 read at the top of the SRAM
        re1 = 1'b1; addr1 = 32'h7FFF8;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("ac4_addr_c%0d", k), 64'(sa1), 64'(18'h3FFFC + 18'((k - 1) / 4)));
            check($sformatf("ac4_ready_c%0d", k), 64'(rdy1), 64'h0);
        end
        tick();
        check("ac4_ready_c17", 64'(rdy1), 64'h1);
        check("ac4_read_data", rd1, 64'hA004_A003_A002_A001);
        re1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
